// File: rtl/mem_access_pkg.sv
// Shared types for the data-bus access controller: sizes, pipeline payload, bus structs, FSM states.
// Optional feature macro used by mem_access: MISALIGN_TRAP_EN.
package mem_access_pkg;

  localparam int XLEN   = 64;
  localparam int OFFS_W = 3;
  localparam int STRB_W = XLEN / 8;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [STRB_W-1:0] strobe_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  function automatic logic [3:0] bytes_of(msize_t m);
    case (m)
      MSIZE1:  bytes_of = 4'd1;
      MSIZE2:  bytes_of = 4'd2;
      MSIZE4:  bytes_of = 4'd4;
      default: bytes_of = 4'd8;
    endcase
  endfunction

  // Byte lanes of an access at offset 0.
  function automatic strobe_t lanes_of(msize_t m);
    case (m)
      MSIZE1:  lanes_of = 8'h01;
      MSIZE2:  lanes_of = 8'h03;
      MSIZE4:  lanes_of = 8'h0F;
      default: lanes_of = 8'hFF;
    endcase
  endfunction

  typedef struct packed {
    logic   memread;
    logic   memwrite;
    msize_t msize;
    logic   msigned;
  } mem_ctl_t;

  typedef struct packed {
    logic     en;
    mem_ctl_t ctl;
    word_t    alu_result;
    word_t    rs2;
  } excute_data_t;

  typedef struct packed {
    logic    valid;
    word_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef logic [1:0] mem_state_t;
  localparam mem_state_t IDLE  = 2'd0;
  localparam mem_state_t BUSY  = 2'd1;
  localparam mem_state_t DONE  = 2'd2;
  localparam mem_state_t DRAIN = 2'd3;

endpackage

// File: rtl/mem_access_load_align.sv
// Load data aligner: shifts the addressed byte lane down and sign/zero-extends to XLEN.
module load_align
  import mem_access_pkg::*;
(
  input  word_t             data,
  input  logic [OFFS_W-1:0] offset,
  input  msize_t            msize,
  input  logic              msigned,
  output word_t             result
);

  word_t shifted;

  assign shifted = data >> {offset, 3'b000};

  always_comb begin
    result = shifted;
    case (msize)
      MSIZE1: result = {{(XLEN-8){msigned & shifted[7]}}, shifted[7:0]};
      MSIZE2: result = {{(XLEN-16){msigned & shifted[15]}}, shifted[15:0]};
      MSIZE4: result = {{(XLEN-32){msigned & shifted[31]}}, shifted[31:0]};
      MSIZE8: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Data-bus access controller between EXECUTE and MEMORY: issues, holds and completes load/store requests.
// Optional macro MISALIGN_TRAP_EN: misaligned accesses are not issued and raise misalign instead.
module mem_access
  import mem_access_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  excute_data_t dataE,
  input  logic         advance,
  input  logic         flush,
  input  dbus_resp_t   dresp,
  output dbus_req_t    dreq,
  output logic         stall,
  output logic         finish,
  output word_t        data1,
  output word_t        data2,
`ifdef MISALIGN_TRAP_EN
  output logic         misalign,
`endif
  output mem_state_t   state
);

  // Handshake: dreq.valid rises in the issue cycle and stays high with stable fields
  // until the cycle dresp.data_ok is seen; data_ok alone completes the access.

  logic              mem_op;
  logic              idle_issue;
  logic              issue;
  logic [OFFS_W-1:0] off_now;
  strobe_t           strobe_now;
  word_t             wdata_now;

  word_t   addr_q, wdata_q;
  msize_t  size_q;
  strobe_t strobe_q;
  logic    signed_q, load_q;

  word_t   cur_addr, cur_wdata, aligned;
  msize_t  cur_size;
  strobe_t cur_strobe;
  logic    cur_signed, cur_load;

  logic unused_bits;
  assign unused_bits = dresp.addr_ok;

  assign mem_op     = dataE.en & (dataE.ctl.memread | dataE.ctl.memwrite);
  assign idle_issue = reset & (state == IDLE) & mem_op & ~flush;
  assign off_now    = dataE.alu_result[OFFS_W-1:0];
  assign strobe_now = dataE.ctl.memread ? '0 : strobe_t'(lanes_of(dataE.ctl.msize) << off_now);
  assign wdata_now  = dataE.rs2 << {off_now, 3'b000};

`ifdef MISALIGN_TRAP_EN
  logic misaligned_now, trap, misalign_q;
  assign misaligned_now = ({1'b0, off_now} & (bytes_of(dataE.ctl.msize) - 4'd1)) != 4'd0;
  assign trap           = idle_issue & misaligned_now;
  assign issue          = idle_issue & ~misaligned_now;
  assign misalign       = misalign_q;
`else
  assign issue = idle_issue;
`endif

  // In IDLE the request comes straight from dataE; afterwards from the copy taken at issue.
  always_comb begin
    cur_addr   = addr_q;
    cur_size   = size_q;
    cur_strobe = strobe_q;
    cur_wdata  = wdata_q;
    cur_signed = signed_q;
    cur_load   = load_q;
    if (state == IDLE) begin
      cur_addr   = dataE.alu_result;
      cur_size   = dataE.ctl.msize;
      cur_strobe = strobe_now;
      cur_wdata  = wdata_now;
      cur_signed = dataE.ctl.msigned;
      cur_load   = dataE.ctl.memread;
    end
  end

  load_align u_load_align (
    .data    (dresp.data),
    .offset  (cur_addr[OFFS_W-1:0]),
    .msize   (cur_size),
    .msigned (cur_signed),
    .result  (aligned)
  );

  assign data1 = cur_load ? aligned : '0;

  always_comb begin
    dreq        = '0;
    dreq.valid  = issue | (state == BUSY) | (state == DRAIN);
    dreq.addr   = cur_addr;
    dreq.size   = cur_size;
    dreq.strobe = dreq.valid ? cur_strobe : '0;
    dreq.data   = cur_wdata;
  end

  assign stall  = (issue & ~dresp.data_ok)
                | ((state == BUSY) & ~dresp.data_ok)
                | (state == DRAIN);
  assign finish = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      data2    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= MSIZE1;
      strobe_q <= '0;
      signed_q <= 1'b0;
      load_q   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      if (state == IDLE) begin
        addr_q   <= dataE.alu_result;
        wdata_q  <= wdata_now;
        size_q   <= dataE.ctl.msize;
        strobe_q <= strobe_now;
        signed_q <= dataE.ctl.msigned;
        load_q   <= dataE.ctl.memread;
      end
      case (state)
        IDLE: begin
          if (issue) begin
            if (dresp.data_ok) begin
              state <= DONE;
              data2 <= data1;
            end else begin
              state <= BUSY;
            end
          end
`ifdef MISALIGN_TRAP_EN
          if (trap) begin
            state      <= DONE;
            data2      <= '0;
            misalign_q <= 1'b1;
          end
`endif
        end
        BUSY: begin
          if (dresp.data_ok) begin
            state <= DONE;
            data2 <= data1;
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DONE: begin
          if (advance | flush) begin
            state <= IDLE;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
          end
        end
        DRAIN: begin
          // The bus cannot abort; wait out the squashed access and drop its data.
          if (dresp.data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access: directed spec vectors plus randomized loads/stores against a byte-level model.
module tb_mem_access;
  import mem_access_pkg::*;

  logic         clk;
  logic         reset;
  excute_data_t dataE;
  logic         advance;
  logic         flush;
  dbus_resp_t   dresp;
  dbus_req_t    dreq;
  logic         stall;
  logic         finish;
  word_t        data1;
  word_t        data2;
  mem_state_t   state;
`ifdef MISALIGN_TRAP_EN
  logic         misalign;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];

  mem_access dut (
    .clk     (clk),
    .reset   (reset),
    .dataE   (dataE),
    .advance (advance),
    .flush   (flush),
    .dresp   (dresp),
    .dreq    (dreq),
    .stall   (stall),
    .finish  (finish),
    .data1   (data1),
    .data2   (data2),
`ifdef MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .state   (state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [63:0] model_load(input logic [63:0] d, input int off, input int n,
                                             input logic sg);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < n; k++)
      if (off + k < 8) r[8*k +: 8] = d[8*(off+k) +: 8];
    if (sg && r[8*n-1])
      for (int k = n; k < 8; k++) r[8*k +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [7:0] model_strobe(input int off, input int n);
    logic [7:0] s;
    for (int i = 0; i < 8; i++) s[i] = (i >= off) && (i < off + n);
    return s;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] v, input int off);
    logic [63:0] r;
    r = '0;
    for (int i = off; i < 8; i++) r[8*i +: 8] = v[8*(i-off) +: 8];
    return r;
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_inputs();
    dataE   = '0;
    advance = 1'b0;
    flush   = 1'b0;
    dresp   = '0;
  endtask

  // ---------------- driver: one complete access ----------------
  task automatic run_access(input logic ld, input msize_t m, input logic sg,
                            input logic [63:0] addr, input logic [63:0] rs2,
                            input logic [63:0] rdata, input int wait_n, input int flush_at,
                            output logic [63:0] o_d2, output logic [63:0] o_strb,
                            output logic [63:0] o_wdata);
    int          off;
    int          n;
    logic        flushed;
    logic [63:0] exp_ld;
    off     = int'(addr[2:0]);
    n       = 1 << int'(m);
    flushed = 1'b0;
    exp_ld  = ld ? model_load(rdata, off, n, sg) : 64'd0;
    o_strb  = '0;
    o_wdata = '0;
    dataE              = '0;
    dataE.en           = 1'b1;
    dataE.ctl.memread  = ld;
    dataE.ctl.memwrite = ~ld;
    dataE.ctl.msize    = m;
    dataE.ctl.msigned  = sg;
    dataE.alu_result   = addr;
    dataE.rs2          = rs2;
    advance            = 1'b0;
    dresp.addr_ok      = 1'b1;
    dresp.data         = rdata;
    for (int c = 0; c <= wait_n; c++) begin
      dresp.data_ok = (c == wait_n);
      flush         = (c == flush_at);
      @(negedge clk);
      check("valid", dreq.valid, 1);
      check("addr", dreq.addr, addr);
      check("size", dreq.size, m);
      check("strobe", dreq.strobe, ld ? 8'h00 : model_strobe(off, n));
      if (!ld) check("wdata", dreq.data, model_wdata(rs2, off));
      if (c == 0) begin
        o_strb  = dreq.strobe;
        o_wdata = dreq.data;
      end
      check("stall", stall, flushed || (c != wait_n));
      check("finish_busy", finish, 0);
      if (c == wait_n && !flushed) begin
        check("data1", data1, exp_ld);
        exp_q.push_back(exp_ld);
      end
      if (c == flush_at) begin
        flushed          = 1'b1;
        dataE            = '0;
        dataE.alu_result = {$urandom, $urandom};
        dataE.rs2        = {$urandom, $urandom};
      end
      tick();
    end
    flush         = 1'b0;
    dresp.data_ok = 1'b0;
    dresp.data    = {$urandom, $urandom};
    if (!flushed) begin
      // A new memory op waiting in DONE must not be issued while DONE holds.
      dataE.alu_result = {$urandom, $urandom};
      dataE.ctl.memread  = 1'b1;
      dataE.ctl.memwrite = 1'b0;
      @(negedge clk);
      check("finish_hold", finish, 1);
      check("valid_done", dreq.valid, 0);
      check("stall_done", stall, 0);
      check("data2_hold", data2, exp_q[0]);
      tick();
      dataE   = '0;
      advance = 1'b1;
      @(negedge clk);
      check("finish_adv", finish, 1);
      check("data2", data2, exp_q.pop_front());
      o_d2 = data2;
      tick();
      advance = 1'b0;
    end else begin
      o_d2 = data2;
    end
    @(negedge clk);
    check("finish_idle", finish, 0);
    check("valid_idle", dreq.valid, 0);
    check("stall_idle", stall, 0);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] d2, sb, wd, addr;
    logic        ld, sg;
    msize_t      m;
    int          wn, fa;

    reset = 1'b0;
    set_idle_inputs();
    #2;
    check("rst_valid", dreq.valid, 0);
    check("rst_strobe", dreq.strobe, 0);
    check("rst_stall", stall, 0);
    check("rst_finish", finish, 0);
    check("rst_data2", data2, 0);
    check("rst_state", state, IDLE);
    tick();
    reset = 1'b1;
    tick();

    // LB signed, three wait cycles
    run_access(1'b1, MSIZE1, 1'b1, 64'h0000_0000_8000_0003, 64'd0,
               64'h0000_0000_8000_0000, 3, -1, d2, sb, wd);
    check("t1_data2", d2, 64'hFFFF_FFFF_FFFF_FF80);

    // SH at byte offset 6
    run_access(1'b0, MSIZE2, 1'b0, 64'h0000_0000_8000_0006, 64'h1234,
               64'd0, 1, -1, d2, sb, wd);
    check("t2_strobe", sb, 64'hC0);
    check("t2_wdata", wd, 64'h1234_0000_0000_0000);
    check("t2_data2", d2, 64'd0);

    // LW unsigned, zero-wait bus
    run_access(1'b1, MSIZE4, 1'b0, 64'h0000_0000_8000_0004, 64'd0,
               64'h89AB_CDEF_0000_0000, 0, -1, d2, sb, wd);
    check("t3_data2", d2, 64'h0000_0000_89AB_CDEF);

    // flush while BUSY, data_ok two cycles after the flush
    run_access(1'b1, MSIZE8, 1'b0, 64'h0000_0000_8000_0010, 64'd0,
               64'h1122_3344_5566_7788, 3, 1, d2, sb, wd);
    check("t4_data2_kept", d2, 64'h0000_0000_89AB_CDEF);

    // asynchronous reset in the middle of a BUSY access
    dataE              = '0;
    dataE.en           = 1'b1;
    dataE.ctl.memread  = 1'b1;
    dataE.ctl.msize    = MSIZE8;
    dataE.alu_result   = 64'h0000_0000_8000_0020;
    dresp              = '0;
    tick();
    #2;
    check("t5_busy_valid", dreq.valid, 1);
    check("t5_pre_data2", data2, 64'h0000_0000_89AB_CDEF);
    reset = 1'b0;
    #1;
    check("t5_valid", dreq.valid, 0);
    check("t5_strobe", dreq.strobe, 0);
    check("t5_stall", stall, 0);
    check("t5_finish", finish, 0);
    check("t5_data2", data2, 0);
    check("t5_state", state, IDLE);
    set_idle_inputs();
    tick();
    reset = 1'b1;
    tick();

`ifdef MISALIGN_TRAP_EN
    dataE              = '0;
    dataE.en           = 1'b1;
    dataE.ctl.memread  = 1'b1;
    dataE.ctl.msize    = MSIZE8;
    dataE.alu_result   = 64'h0000_0000_8000_0004;
    @(negedge clk);
    check("t6_valid", dreq.valid, 0);
    check("t6_stall", stall, 0);
    tick();
    dataE   = '0;
    advance = 1'b1;
    @(negedge clk);
    check("t6_finish", finish, 1);
    check("t6_misalign", misalign, 1);
    check("t6_data2", data2, 0);
    tick();
    advance = 1'b0;
    @(negedge clk);
    check("t6_misalign_clr", misalign, 0);
    tick();
`endif

    // randomized accesses
    for (int i = 0; i < 40; i++) begin
      ld   = 1'($urandom_range(0, 1));
      m    = msize_t'($urandom_range(0, 3));
      sg   = 1'($urandom_range(0, 1));
      addr = {32'd0, $urandom};
`ifdef MISALIGN_TRAP_EN
      addr[2:0] = addr[2:0] & ~3'((1 << int'(m)) - 1);
`endif
      wn = $urandom_range(0, 3);
      fa = (wn >= 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, wn - 1)) : -1;
      run_access(ld, m, sg, addr, {$urandom, $urandom}, {$urandom, $urandom}, wn, fa,
                 d2, sb, wd);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
